line_burst_adaptor: RTL and testbench

Responder for the L2 line interface: accepts one full-cache-line read or write request from the cache arbiter's L2 port and carries it out as a fixed-length burst of 64-bit beats on the physical-memory port. Read beats are assembled into a line buffer and returned with a single-cycle `line_resp`. For writes, a captured line is streamed out beat by beat. Sits between the arbiter's `l2_*` outputs (or the L2 cache's miss port) and main memory.

---
 rtl/line_adaptor_pkg.sv | 19 +
 rtl/line_burst_adaptor.sv | 129 ++++++++++++
 tb/tb_line_burst_adaptor.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/line_adaptor_pkg.sv
// Shared definitions for the L2 line burst adaptor.
//   line_state_t : controller state encoding
//   S_BEAT_DEF   : default burst beat width in bits
//   N_BEATS_DEF  : default beats per cache line
//   BEAT_IDX_W   : beat counter width for the default geometry
package line_adaptor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } line_state_t;

    localparam int S_BEAT_DEF  = 64;
    localparam int N_BEATS_DEF = 4;
    localparam int BEAT_IDX_W  = $clog2(N_BEATS_DEF);

endpackage

// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor
// Carries out one full-line read or write from the L2 line port as a
// fixed-length burst of beats on the physical-memory port.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   line_read      line read request, held until line_resp
//   line_write     line write request, held until line_resp
//   line_address   line address (low s_offset bits ignored)
//   line_wdata     write line, valid with line_write
//   line_resp      one-cycle completion pulse
//   line_rdata     assembled read line, valid with line_resp
//   pmem_read      burst read, held for the burst
//   pmem_write     burst write, held for the burst
//   pmem_address   line-aligned burst base address
//   pmem_wdata     current write beat
//   pmem_rdata     read beat, valid with pmem_resp
//   pmem_resp      one beat transferred this cycle
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for a line request; only state sampling line_*
// READ  | pmem_read burst, one buffer slice filled per pmem_resp
// WRITE | pmem_write burst, one buffer slice sent per pmem_resp
// DONE  | line_resp pulse for one cycle, then back to IDLE
module line_burst_adaptor
    import line_adaptor_pkg::*;
#(
    parameter int s_offset = 5,
    parameter int s_line   = 8 * (2 ** s_offset),
    parameter int s_beat   = S_BEAT_DEF,
    parameter int n_beats  = s_line / s_beat
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [31:0]       line_address,
    input  logic [s_line-1:0] line_wdata,
    output logic              line_resp,
    output logic [s_line-1:0] line_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [s_beat-1:0] pmem_wdata,
    input  logic [s_beat-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int IDX_W = $clog2(n_beats);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(n_beats - 1);

    line_state_t       state_q, state_d;
    logic [IDX_W-1:0]  beat_q;
    logic [31:0]       addr_q;
    logic [s_beat-1:0] line_buf [n_beats];

    wire last_beat = (beat_q == LAST_BEAT);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (line_read)       state_d = READ;
                else if (line_write) state_d = WRITE;
            end
            READ:    if (pmem_resp && last_beat) state_d = DONE;
            WRITE:   if (pmem_resp && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // address, beat counter and line buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            beat_q <= '0;
            for (int k = 0; k < n_beats; k++) line_buf[k] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (line_read || line_write) begin
                        addr_q <= {line_address[31:s_offset], {s_offset{1'b0}}};
                        beat_q <= '0;
                    end
                    // read wins a simultaneous request, so the write line is dropped
                    if (!line_read && line_write) begin
                        for (int k = 0; k < n_beats; k++)
                            line_buf[k] <= line_wdata[k*s_beat +: s_beat];
                    end
                end
                READ: begin
                    if (pmem_resp) begin
                        line_buf[beat_q] <= pmem_rdata;
                        beat_q           <= beat_q + 1'b1;
                    end
                end
                WRITE: begin
                    if (pmem_resp) beat_q <= beat_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // outputs decoded from registered state only
    always_comb begin
        line_resp    = (state_q == DONE);
        pmem_read    = (state_q == READ);
        pmem_write   = (state_q == WRITE);
        pmem_address = addr_q;
        pmem_wdata   = '0;
        line_rdata   = '0;
        if (state_q == WRITE) pmem_wdata = line_buf[beat_q];
        if (state_q == DONE) begin
            for (int k = 0; k < n_beats; k++)
                line_rdata[k*s_beat +: s_beat] = line_buf[k];
        end
    end

endmodule

// File: tb/tb_line_burst_adaptor.sv
module tb_line_burst_adaptor;

    logic         clk;
    logic         rst_n;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_address;
    logic [255:0] line_wdata;
    logic         line_resp;
    logic [255:0] line_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    line_burst_adaptor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .line_read    (line_read),
        .line_write   (line_write),
        .line_address (line_address),
        .line_wdata   (line_wdata),
        .line_resp    (line_resp),
        .line_rdata   (line_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".line_resp"},    line_resp,    '0);
        chk({tag, ".pmem_read"},    pmem_read,    '0);
        chk({tag, ".pmem_write"},   pmem_write,   '0);
        chk({tag, ".pmem_address"}, pmem_address, '0);
        chk({tag, ".pmem_wdata"},   pmem_wdata,   '0);
        chk({tag, ".line_rdata"},   line_rdata,   '0);
    endtask

    // Request in cycle 0, beats back-to-back in cycles 1..4, line_resp in cycle 5.
    // Returns in cycle 6 (IDLE) with all requests dropped.
    task automatic read_burst(input string tag, input logic [31:0] addr,
                              input logic [31:0] exp_addr, input logic [255:0] line);
        line_read    = 1'b1;
        line_address = addr;
        tick();
        chk({tag, ".addr"}, pmem_address, exp_addr);
        for (int k = 0; k < 4; k++) begin
            chk({tag, ".pmem_read"}, pmem_read, 1'b1);
            chk({tag, ".no_resp"},   line_resp, 1'b0);
            pmem_resp  = 1'b1;
            pmem_rdata = line[k*64 +: 64];
            tick();
        end
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        line_read  = 1'b0;
        chk({tag, ".resp"},      line_resp,  1'b1);
        chk({tag, ".rdata"},     line_rdata, line);
        chk({tag, ".read_drop"}, pmem_read,  1'b0);
        tick();
        chk({tag, ".resp_once"}, line_resp,  1'b0);
        chk({tag, ".idle_rd"},   pmem_read,  1'b0);
        chk({tag, ".idle_wr"},   pmem_write, 1'b0);
    endtask

    logic [255:0] rd_line, wr_line, line_b, line_c;
    logic [63:0]  wbeat [4];

    initial begin
        rst_n        = 1'b0;
        line_read    = 1'b0;
        line_write   = 1'b0;
        line_address = '0;
        line_wdata   = '0;
        pmem_rdata   = '0;
        pmem_resp    = 1'b0;
        #13;
        chk_all_zero("reset");
        #10;
        rst_n = 1'b1;
        tick();
        chk_all_zero("post_reset");

        // read, 4 consecutive beats
        rd_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        read_burst("rd1", 32'h0000_1234, 32'h0000_1220, rd_line);

        // handoff: write asserted in the IDLE cycle after DONE, with stalls
        for (int k = 0; k < 4; k++) wbeat[k] = {8{8'hA0 + 8'(k)}};
        wr_line      = {wbeat[3], wbeat[2], wbeat[1], wbeat[0]};
        line_write   = 1'b1;
        line_address = 32'h8000_0040;
        line_wdata   = wr_line;
        tick();                                       // w1
        line_wdata = '1;                              // ignored mid-burst
        chk("wr.pmem_write", pmem_write, 1'b1);
        chk("wr.no_overlap", pmem_read,  1'b0);
        chk("wr.addr",       pmem_address, 32'h8000_0040);
        chk("wr.w1",         pmem_wdata, wbeat[0]);
        tick();                                       // w2: resp
        chk("wr.w2", pmem_wdata, wbeat[0]);
        pmem_resp = 1'b1;
        tick();                                       // w3: resp
        chk("wr.w3", pmem_wdata, wbeat[1]);
        tick();                                       // w4
        pmem_resp = 1'b0;
        chk("wr.w4", pmem_wdata, wbeat[2]);
        tick();                                       // w5
        chk("wr.w5", pmem_wdata, wbeat[2]);
        chk("wr.w5_resp", line_resp, 1'b0);
        tick();                                       // w6: resp
        chk("wr.w6", pmem_wdata, wbeat[2]);
        pmem_resp = 1'b1;
        tick();                                       // w7: resp
        chk("wr.w7", pmem_wdata, wbeat[3]);
        chk("wr.w7_resp", line_resp, 1'b0);
        tick();                                       // w8: DONE, spurious resp
        pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        line_write = 1'b0;
        chk("wr.resp",       line_resp,  1'b1);
        chk("wr.write_drop", pmem_write, 1'b0);
        chk("wr.buf",        line_rdata, wr_line);
        tick();                                       // IDLE, resp still high
        chk("spur.idle_resp", line_resp,  1'b0);
        chk("spur.idle_rd",   pmem_read,  1'b0);
        chk("spur.idle_wr",   pmem_write, 1'b0);
        tick();
        chk("spur.idle2_rd",  pmem_read,  1'b0);
        chk("spur.idle2_wd",  pmem_wdata, '0);
        pmem_resp  = 1'b0;
        pmem_rdata = '0;

        // simultaneous read+write: read wins, stall after beat 1
        line_b = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                  64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
        line_read    = 1'b1;
        line_write   = 1'b1;
        line_address = 32'h0000_201F;
        line_wdata   = '1;
        tick();
        chk("both.read",  pmem_read,  1'b1);
        chk("both.write", pmem_write, 1'b0);
        chk("both.addr",  pmem_address, 32'h0000_2000);
        for (int c = 0; c < 5; c++) begin
            // beats at c = 0, 2, 3, 4; stall at c = 1
            pmem_resp  = (c != 1);
            pmem_rdata = line_b[(c == 0 ? 0 : c - 1)*64 +: 64];
            chk("both.busy", line_resp, 1'b0);
            tick();
        end
        pmem_resp  = 1'b0;
        line_read  = 1'b0;
        line_write = 1'b0;
        chk("both.resp",  line_resp,  1'b1);
        chk("both.rdata", line_rdata, line_b);
        tick();
        chk("both.idle", line_resp, 1'b0);

        // async reset after beat 2 of a read
        line_read    = 1'b1;
        line_address = 32'h0000_3000;
        tick();
        for (int k = 0; k < 2; k++) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {8{8'h50 + 8'(k)}};
            tick();
        end
        pmem_resp = 1'b0;
        line_read = 1'b0;
        chk("rst.busy", pmem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst.async");
        tick();
        chk_all_zero("rst.held");
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst.no_resp", line_resp, 1'b0);
            chk("rst.no_rd",   pmem_read, 1'b0);
        end

        // fresh read after reset
        line_c = {64'hCAFE_0003_CAFE_0003, 64'hCAFE_0002_CAFE_0002,
                  64'hCAFE_0001_CAFE_0001, 64'hCAFE_0000_CAFE_0000};
        read_burst("rd2", 32'h0000_3008, 32'h0000_3000, line_c);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
